// File: rtl/exec_ctrl_pkg.sv
// Shared types and defaults for the execute-stage sequencer.
package exec_ctrl_pkg;

    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } exec_ctrl_state_t;

endpackage

// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: issue, wait for FPU, hand result to memory stage,
// turn a mispredict at completion into flush/pc_load, trap a hung FPU.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_multi,
    output logic        exec_enable,
    input  logic        exec_fin,
    input  logic        exec_miss,
    output logic        cap_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        flush,
    output logic        pc_load,
    output logic        timeout_err,
    output logic [31:0] wait_cycles
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    exec_ctrl_state_t state_q;
    logic             multi_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wait_cycles_q;

    // Saturate rather than wrap so a mis-sized TIMEOUT can never re-arm.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        in_ready    = 1'b0;
        exec_enable = 1'b0;
        cap_en      = 1'b0;
        out_valid   = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE:  in_ready = 1'b1;
            ISSUE: begin
                exec_enable = 1'b1;
                cap_en      = !multi_q || exec_fin;
            end
            WAIT:  cap_en = exec_fin;
            DONE:  begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            ERR:   timeout_err = 1'b1;
            default: ;
        endcase
    end

    // A mispredict only matters on the cycle the result is captured.
    assign flush       = exec_miss & cap_en;
    assign pc_load     = exec_miss & cap_en;
    assign wait_cycles = wait_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            multi_q       <= 1'b0;
            cnt_q         <= '0;
            wait_cycles_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        multi_q <= in_multi;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= cap_en ? DONE : WAIT;
                end
                WAIT: begin
                    cnt_q         <= cnt_d;
                    wait_cycles_q <= wait_cycles_q + 32'd1;
                    if (exec_fin)
                        state_q <= DONE;
                    else if (cnt_q == CNT_LAST)
                        state_q <= ERR;
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            multi_q <= in_multi;
                            state_q <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                ERR: ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios plus randomized
// instruction streams checked against a transaction-level schedule model.
module tb_exec_ctrl;

    localparam int TO = 8;

    // Observation vector: {in_ready, exec_enable, cap_en, out_valid, flush, pc_load, timeout_err}
    localparam logic [6:0] O_RDY = 7'b1000000;
    localparam logic [6:0] O_EN  = 7'b0100000;
    localparam logic [6:0] O_CAP = 7'b0010000;
    localparam logic [6:0] O_OV  = 7'b0001000;
    localparam logic [6:0] O_FL  = 7'b0000110;
    localparam logic [6:0] O_ERR = 7'b0000001;
    localparam logic [6:0] O_NON = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_multi = 1'b0, exec_fin = 1'b0, exec_miss = 1'b0, out_ready = 1'b0;
    logic        in_ready, exec_enable, cap_en, out_valid, flush, pc_load, timeout_err;
    logic [31:0] wait_cycles;
    logic [6:0]  obs;
    logic [31:0] exp_wc = 32'd0;
    int          n_tests = 0;
    int          n_fail  = 0;

    assign obs = {in_ready, exec_enable, cap_en, out_valid, flush, pc_load, timeout_err};

    always #5 clk = ~clk;

    exec_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_multi(in_multi),
        .exec_enable(exec_enable), .exec_fin(exec_fin), .exec_miss(exec_miss),
        .cap_en(cap_en), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .pc_load(pc_load), .timeout_err(timeout_err),
        .wait_cycles(wait_cycles)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle's inputs after the falling edge; outputs settle by +1.
    task automatic drv(input logic iv, input logic im, input logic fin, input logic miss, input logic ordy);
        @(negedge clk);
        in_valid = iv; in_multi = im; exec_fin = fin; exec_miss = miss; out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_multi = 1'b0; exec_fin = 1'b0; exec_miss = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_wc = 32'd0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== O_RDY) begin n_fail++; $display("FAIL reset_outs got=%b exp=%b", obs, O_RDY); end
        n_tests++;
        if (wait_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_wc got=%0d exp=0", wait_cycles); end
    endtask

    task automatic test_alu();
        logic [6:0] e [4];
        e = '{O_RDY, O_EN | O_CAP, O_OV | O_RDY, O_RDY};
        for (int c = 0; c < 4; c++) begin
            drv(c == 0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (obs !== e[c]) begin n_fail++; $display("FAIL alu_cyc%0d got=%b exp=%b", c, obs, e[c]); end
        end
    endtask

    task automatic test_fpu();
        logic [6:0] e [7];
        e = '{O_RDY, O_EN, O_NON, O_NON, O_CAP, O_OV, O_OV | O_RDY};
        for (int c = 0; c < 7; c++) begin
            drv(c == 0, c == 0, c == 4, 1'b0, c == 6);
            n_tests++;
            if (obs !== e[c]) begin n_fail++; $display("FAIL fpu_cyc%0d got=%b exp=%b", c, obs, e[c]); end
        end
        exp_wc += 32'd3;
        n_tests++;
        if (wait_cycles !== exp_wc) begin n_fail++; $display("FAIL fpu_wc got=%0d exp=%0d", wait_cycles, exp_wc); end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_miss();
        logic [6:0] e [5];
        e = '{O_RDY, O_EN | O_CAP | O_FL, O_OV, O_OV | O_RDY, O_RDY};
        for (int c = 0; c < 5; c++) begin
            drv(c == 0, 1'b0, 1'b0, c == 1 || c == 2 || c == 3, c >= 3);
            n_tests++;
            if (obs !== e[c]) begin n_fail++; $display("FAIL miss_cyc%0d got=%b exp=%b", c, obs, e[c]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e;
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drv(1'b1, rb(), rb(), rb(), 1'b0);
            n_tests++;
            if (obs !== O_OV) begin n_fail++; $display("FAIL bp_hold%0d got=%b exp=%b", c, obs, O_OV); end
        end
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        e = O_OV | O_RDY;
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL bp_handoff got=%b exp=%b", obs, e); end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e = O_EN | O_CAP;
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL bp_reissue got=%b exp=%b", obs, e); end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs !== O_RDY) begin n_fail++; $display("FAIL bp_idle got=%b exp=%b", obs, O_RDY); end
    endtask

    // Completion on the last permitted WAIT cycle wins over the timeout.
    task automatic test_fin_boundary();
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            drv(1'b0, 1'b0, k == TO, 1'b0, 1'b0);
            exp_wc++;
        end
        n_tests++;
        if (obs !== O_CAP) begin n_fail++; $display("FAIL bound_cap got=%b exp=%b", obs, O_CAP); end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (obs !== (O_OV | O_RDY)) begin n_fail++; $display("FAIL bound_done got=%b exp=%b", obs, O_OV | O_RDY); end
        n_tests++;
        if (wait_cycles !== exp_wc) begin n_fail++; $display("FAIL bound_wc got=%0d exp=%0d", wait_cycles, exp_wc); end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs !== O_NON) begin n_fail++; $display("FAIL to_wait%0d got=%b exp=%b", k, obs, O_NON); end
            exp_wc++;
        end
        for (int c = 0; c < 4; c++) begin
            drv(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            n_tests++;
            if (obs !== O_ERR) begin n_fail++; $display("FAIL to_err%0d got=%b exp=%b", c, obs, O_ERR); end
        end
        n_tests++;
        if (wait_cycles !== exp_wc) begin n_fail++; $display("FAIL to_wc got=%0d exp=%0d", wait_cycles, exp_wc); end
        do_reset();
        n_tests++;
        if (obs !== O_RDY || wait_cycles !== 32'd0) begin
            n_fail++; $display("FAIL to_rst got=%b/%0d exp=%b/0", obs, wait_cycles, O_RDY);
        end
    endtask

    task automatic test_reset_wait();
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        n_tests++;
        if (obs !== O_RDY || wait_cycles !== 32'd0) begin
            n_fail++; $display("FAIL rstwait got=%b/%0d exp=%b/0", obs, wait_cycles, O_RDY);
        end
        drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs !== O_RDY) begin n_fail++; $display("FAIL rstwait_idle got=%b exp=%b", obs, O_RDY); end
    endtask

    // Each instruction is scheduled from its own attributes: accept, one issue
    // cycle, lat WAIT cycles (FPU), a random hold in DONE, then handoff.
    task automatic test_random();
        bit         in_done = 1'b0;
        int         lat, hold;
        logic       mi, ms;
        bit         cap0;
        logic [6:0] e;
        for (int n = 0; n < 150; n++) begin
            mi  = rb();
            lat = mi ? $urandom_range(0, TO) : 0;
            if (in_done) begin
                drv(1'b1, mi, rb(), rb(), 1'b1);
                e = O_OV | O_RDY;
            end else begin
                drv(1'b1, mi, rb(), rb(), rb());
                e = O_RDY;
            end
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL rnd%0d_accept got=%b exp=%b", n, obs, e); end

            ms   = rb();
            cap0 = !mi || lat == 0;
            drv(rb(), rb(), mi ? (lat == 0) : rb(), ms, rb());
            e = O_EN | (cap0 ? (O_CAP | (ms ? O_FL : O_NON)) : O_NON);
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL rnd%0d_issue got=%b exp=%b", n, obs, e); end

            for (int k = 1; k <= (cap0 ? 0 : lat); k++) begin
                ms = rb();
                drv(rb(), rb(), k == lat, ms, rb());
                e = (k == lat) ? (O_CAP | (ms ? O_FL : O_NON)) : O_NON;
                n_tests++;
                if (obs !== e || wait_cycles !== exp_wc) begin
                    n_fail++; $display("FAIL rnd%0d_wait%0d got=%b/%0d exp=%b/%0d", n, k, obs, wait_cycles, e, exp_wc);
                end
                exp_wc++;
            end

            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                drv(rb(), rb(), rb(), rb(), 1'b0);
                n_tests++;
                if (obs !== O_OV || wait_cycles !== exp_wc) begin
                    n_fail++; $display("FAIL rnd%0d_hold got=%b/%0d exp=%b/%0d", n, obs, wait_cycles, O_OV, exp_wc);
                end
            end

            if ($urandom_range(0, 2) != 0) begin
                in_done = 1'b1;
            end else begin
                drv(1'b0, rb(), rb(), rb(), 1'b1);
                e = O_OV | O_RDY;
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL rnd%0d_drain got=%b exp=%b", n, obs, e); end
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    drv(1'b0, rb(), rb(), rb(), rb());
                    n_tests++;
                    if (obs !== O_RDY) begin n_fail++; $display("FAIL rnd%0d_gap got=%b exp=%b", n, obs, O_RDY); end
                end
                in_done = 1'b0;
            end
        end
        if (in_done) drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs !== O_RDY || wait_cycles !== exp_wc) begin
            n_fail++; $display("FAIL rnd_end got=%b/%0d exp=%b/%0d", obs, wait_cycles, O_RDY, exp_wc);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fpu();
        test_miss();
        test_back_to_back();
        test_fin_boundary();
        test_random();
        test_reset_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
